// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the CPU data port. A word-organised,
//   little-endian data RAM sits behind a valid/ready request/response
//   handshake. Every access takes a fixed, parameterised latency. Only one
//   transaction is outstanding at a time.
//
// Parameters
//   ADDR_WIDTH : byte-address bits decoded. Storage holds 2^(ADDR_WIDTH-2) words.
//   LATENCY    : cycles from request acceptance to resp_valid (1..15).
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-low
//   req_valid  : request present
//   req_ready  : responder idle and able to accept a request
//   req_addr   : byte address
//   req_wdata  : store data; the lane is taken from the low bits
//   req_we     : 1 = store, 0 = load
//   req_width  : funct3 width (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   resp_valid : response present
//   resp_ready : CPU accepts the response
//   resp_rdata : extended load data; 0 for stores and errors
//   resp_err   : access rejected; qualified by resp_valid
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [2:0]  req_width,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned WORDS = 1 << (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       latch;
    logic       access;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [2:0]  width_q;

    logic [31:0] mem [WORDS];

    logic [31:0]           op_addr;
    logic [31:0]           op_wdata;
    logic                  op_we;
    logic [2:0]            op_width;
    logic [ADDR_WIDTH-3:0] op_widx;
    logic                  op_err;
    logic                  lane_ok;
    logic [3:0]            op_be;
    logic [31:0]           op_wlane;
    logic [31:0]           rword;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;
    logic [31:0]           ldata;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // With LATENCY=1 the access happens on the acceptance edge itself. The
    // operands therefore come straight from the request ports while IDLE,
    // and from the latched copy otherwise.
    always_comb begin
        if (state == IDLE) begin
            op_addr  = req_addr;
            op_wdata = req_wdata;
            op_we    = req_we;
            op_width = req_width;
        end else begin
            op_addr  = addr_q;
            op_wdata = wdata_q;
            op_we    = we_q;
            op_width = width_q;
        end
    end

    assign op_widx = op_addr[ADDR_WIDTH-1:2];

    always_comb begin
        lane_ok = 1'b0;
        case (op_width)
            3'b000, 3'b100: lane_ok = 1'b1;
            3'b001, 3'b101: lane_ok = ~op_addr[0];
            3'b010:         lane_ok = (op_addr[1:0] == 2'b00);
            default:        lane_ok = 1'b0;
        endcase
        op_err = ~lane_ok
               | (op_we & op_width[2])
               | ((op_addr >> ADDR_WIDTH) != '0);
    end

    // Store lane steering: replicate the low bits across the word and let
    // the byte enables pick the target lane.
    always_comb begin
        op_be    = 4'b1111;
        op_wlane = op_wdata;
        case (op_width[1:0])
            2'b00: begin
                op_be    = 4'b0001 << op_addr[1:0];
                op_wlane = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                op_be    = op_addr[1] ? 4'b1100 : 4'b0011;
                op_wlane = {2{op_wdata[15:0]}};
            end
            default: begin
                op_be    = 4'b1111;
                op_wlane = op_wdata;
            end
        endcase
    end

    always_comb begin
        rword = mem[op_widx];
        rbyte = rword[8*op_addr[1:0] +: 8];
        rhalf = op_addr[1] ? rword[31:16] : rword[15:0];
        case (op_width)
            3'b000:  ldata = {{24{rbyte[7]}}, rbyte};
            3'b100:  ldata = {24'h0, rbyte};
            3'b001:  ldata = {{16{rhalf[15]}}, rhalf};
            3'b101:  ldata = {16'h0, rhalf};
            default: ldata = rword;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    latch   = 1'b1;
                    cnt_nxt = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        access    = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            width_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                we_q    <= req_we;
                width_q <= req_width;
            end
            if (access) begin
                resp_err   <= op_err;
                resp_rdata <= (op_err || op_we) ? '0 : ldata;
            end
        end
    end

    // Storage is not reset. Reset does suppress a pending write.
    always_ff @(posedge clk) begin
        if (rst && access && op_we && !op_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (op_be[i]) begin
                    mem[op_widx][8*i +: 8] <= op_wlane[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam logic [2:0] WB  = 3'b000;
    localparam logic [2:0] WH  = 3'b001;
    localparam logic [2:0] WW  = 3'b010;
    localparam logic [2:0] WBU = 3'b100;
    localparam logic [2:0] WHU = 3'b101;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst        [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        req_we     [3];
    logic [2:0]  req_width  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .ADDR_WIDTH(17),
            .LATENCY(g == 0 ? 2 : (g == 1 ? 4 : 1))
        ) u_dut (
            .clk(clk),
            .rst(rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_addr(req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_we(req_we[g]),
            .req_width(req_width[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err(resp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    function automatic vec_t mk(input string nm, input logic we, input logic [2:0] w,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee, input int h);
        vec_t v;
        v.name = nm; v.we = we; v.width = w; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.hold = h;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One full transaction: drive, accept, wait, optional backpressure, handshake.
    task automatic txn(input int d, input vec_t v);
        exp_t e;
        int   cyc;
        @(negedge clk);
        chk({v.name, " req_ready idle"}, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = v.we;
        req_width[d] = v.width;
        req_addr[d]  = v.addr;
        req_wdata[d] = v.wdata;
        @(posedge clk);
        sb.push_back('{v.exp_rdata, v.exp_err});
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom();
        req_wdata[d] = $urandom();
        req_width[d] = 3'($urandom());
        req_we[d]    = 1'($urandom());
        cyc = 1;
        while (!resp_valid[d] && cyc < 40) begin
            chk({v.name, " req_ready wait"}, 32'(req_ready[d]), 32'd0);
            @(negedge clk);
            cyc++;
        end
        chk({v.name, " latency"}, 32'(cyc), 32'(lat_of(d)));
        if (!resp_valid[d]) begin
            void'(sb.pop_front());
            return;
        end
        for (int i = 0; i < v.hold; i++) begin
            chk({v.name, " hold valid"}, 32'(resp_valid[d]), 32'd1);
            chk({v.name, " hold rdata"}, resp_rdata[d], v.exp_rdata);
            chk({v.name, " hold err"}, 32'(resp_err[d]), 32'(v.exp_err));
            chk({v.name, " hold req_ready"}, 32'(req_ready[d]), 32'd0);
            // A competing store offered while busy must be ignored.
            req_valid[d] = 1'b1;
            req_we[d]    = 1'b1;
            req_width[d] = WW;
            req_addr[d]  = v.addr & 32'hFFFF_FFFC;
            req_wdata[d] = $urandom();
            @(negedge clk);
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        if (sb.size() == 0) begin
            chk({v.name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({v.name, " valid"}, 32'(resp_valid[d]), 32'd1);
            chk({v.name, " rdata"}, resp_rdata[d], e.rdata);
            chk({v.name, " err"}, 32'(resp_err[d]), 32'(e.err));
        end
        @(negedge clk);
        resp_ready[d] = 1'b0;
        chk({v.name, " valid drop"}, 32'(resp_valid[d]), 32'd0);
        chk({v.name, " req_ready back"}, 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        vec_t t0[$];
        vec_t t1[$];
        vec_t t2[$];

        t0.push_back(mk("sw100",       1, WW,     32'h100,      32'hDEADBEEF, 32'h0,        0, 0));
        t0.push_back(mk("lw100",       0, WW,     32'h100,      32'h0,        32'hDEADBEEF, 0, 0));
        t0.push_back(mk("sw104",       1, WW,     32'h104,      32'h80FF7F01, 32'h0,        0, 0));
        t0.push_back(mk("lb107",       0, WB,     32'h107,      32'h0,        32'hFFFFFF80, 0, 0));
        t0.push_back(mk("lbu107",      0, WBU,    32'h107,      32'h0,        32'h00000080, 0, 0));
        t0.push_back(mk("lh104",       0, WH,     32'h104,      32'h0,        32'h00007F01, 0, 0));
        t0.push_back(mk("lhu106",      0, WHU,    32'h106,      32'h0,        32'h000080FF, 0, 0));
        t0.push_back(mk("lh106",       0, WH,     32'h106,      32'h0,        32'hFFFF80FF, 0, 0));
        t0.push_back(mk("lb105",       0, WB,     32'h105,      32'h0,        32'h0000007F, 0, 0));
        t0.push_back(mk("sw108",       1, WW,     32'h108,      32'h11223344, 32'h0,        0, 0));
        t0.push_back(mk("sb109",       1, WB,     32'h109,      32'h555555AA, 32'h0,        0, 0));
        t0.push_back(mk("sh10a",       1, WH,     32'h10A,      32'h7777BBCC, 32'h0,        0, 0));
        t0.push_back(mk("lw108",       0, WW,     32'h108,      32'h0,        32'hBBCCAA44, 0, 0));
        t0.push_back(mk("lw102_err",   0, WW,     32'h102,      32'h0,        32'h0,        1, 0));
        t0.push_back(mk("sh10b_err",   1, WH,     32'h10B,      32'h0000FFFF, 32'h0,        1, 0));
        t0.push_back(mk("w011_err",    0, 3'b011, 32'h108,      32'h0,        32'h0,        1, 0));
        t0.push_back(mk("lw20000_err", 0, WW,     32'h00020000, 32'h0,        32'h0,        1, 0));
        t0.push_back(mk("sbu_err",     1, WBU,    32'h108,      32'h000000EE, 32'h0,        1, 0));
        t0.push_back(mk("shu_err",     1, WHU,    32'h108,      32'h0000EEEE, 32'h0,        1, 0));
        t0.push_back(mk("w110_err",    1, 3'b110, 32'h108,      32'hFFFFFFFF, 32'h0,        1, 0));
        t0.push_back(mk("w111_err",    0, 3'b111, 32'h108,      32'h0,        32'h0,        1, 0));
        t0.push_back(mk("sw10a_err",   1, WW,     32'h10A,      32'h0,        32'h0,        1, 0));
        t0.push_back(mk("lwhigh_err",  0, WW,     32'h80000108, 32'h0,        32'h0,        1, 0));
        t0.push_back(mk("lw108_after", 0, WW,     32'h108,      32'h0,        32'hBBCCAA44, 0, 0));
        t0.push_back(mk("sw_top",      1, WW,     32'h1FFFC,    32'hA5A55A5A, 32'h0,        0, 0));
        t0.push_back(mk("lw_top",      0, WW,     32'h1FFFC,    32'h0,        32'hA5A55A5A, 0, 0));
        t0.push_back(mk("lhu_top",     0, WHU,    32'h1FFFE,    32'h0,        32'h0000A5A5, 0, 0));
        t0.push_back(mk("lw_bp",       0, WW,     32'h108,      32'h0,        32'hBBCCAA44, 0, 5));
        t0.push_back(mk("lw108_final", 0, WW,     32'h108,      32'h0,        32'hBBCCAA44, 0, 0));

        t1.push_back(mk("l4_sw110_0",  1, WW,     32'h110,      32'h0,        32'h0,        0, 0));
        t1.push_back(mk("l4_lw110",    0, WW,     32'h110,      32'h0,        32'h0,        0, 0));
        t1.push_back(mk("l4_lh_err",   0, WH,     32'h111,      32'h0,        32'h0,        1, 2));

        t2.push_back(mk("l1_sw200",    1, WW,     32'h200,      32'hCAFEF00D, 32'h0,        0, 0));
        t2.push_back(mk("l1_lhu202",   0, WHU,    32'h202,      32'h0,        32'h0000CAFE, 0, 0));
        t2.push_back(mk("l1_lb200",    0, WB,     32'h200,      32'h0,        32'h0000000D, 0, 0));
        t2.push_back(mk("l1_lb203",    0, WB,     32'h203,      32'h0,        32'hFFFFFFCA, 0, 0));
        t2.push_back(mk("l1_lw201_err",0, WW,     32'h201,      32'h0,        32'h0,        1, 1));

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0; req_valid[d] = 1'b0; resp_ready[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; req_we[d] = 1'b0; req_width[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset valid d%0d", d), 32'(resp_valid[d]), 32'd0);
            chk($sformatf("reset rdata d%0d", d), resp_rdata[d], 32'd0);
            chk($sformatf("reset err d%0d", d), 32'(resp_err[d]), 32'd0);
            rst[d] = 1'b1;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset req_ready d%0d", d), 32'(req_ready[d]), 32'd1);
        end

        foreach (t0[i]) txn(0, t0[i]);
        foreach (t1[i]) txn(1, t1[i]);
        foreach (t2[i]) txn(2, t2[i]);

        // LATENCY=4: reset lands two edges after acceptance, so the store
        // must never commit and no response may appear.
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_width[1] = WW;
        req_addr[1] = 32'h110; req_wdata[1] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        chk("midrst req_ready", 32'(req_ready[1]), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("midrst no resp", 32'(resp_valid[1]), 32'd0);
            @(negedge clk);
        end
        txn(1, mk("l4_lw110_after_rst", 0, WW, 32'h110, 32'h0, 32'h0, 0, 0));

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
